// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_pkg : shared types and sizing helpers for the window generator         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cnn_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int padded_size(input int img, input int pad);
        return img + 2 * pad;
    endfunction

    function automatic int window_count(input int th, input int tw, input int k, input int stride);
        return ((th - k) / stride + 1) * ((tw - k) / stride + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_gen_if : pixel stream in, K x K window stream out                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface window_gen_if
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = 3
) ();

    logic [DATA_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [K*K*DATA_W-1:0] out_window;
    logic                  out_valid;
    logic                  out_last;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_window, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_window, out_valid, out_last
    );

endinterface
`default_nettype wire

// File: rtl/row_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | row_delay : DEPTH-deep enabled delay line holding one padded row           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module row_delay
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 30
) (
    input  wire logic              clk,
    input  wire logic              en_i,
    input  wire logic [DATA_W-1:0] d_i,
    output logic      [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_gen : raster pixel stream -> zero-padded, strided K x K windows     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int STRIDE = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   clr,
    window_gen_if.slave bus,
    output logic        busy
);

    localparam int TW    = padded_size(IMG_W, PAD);
    localparam int TH    = padded_size(IMG_H, PAD);
    localparam int N_WIN = window_count(TH, TW, K, STRIDE);
    localparam int PC_W  = $clog2(TW);
    localparam int PR_W  = $clog2(TH);
    localparam int SP_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WC_W  = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    localparam int HW    = K * (K - 1) * DATA_W;

    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(TW - 1);
    localparam logic [PR_W-1:0] PR_LAST  = PR_W'(TH - 1);
    localparam logic [SP_W-1:0] SP_LAST  = SP_W'(STRIDE - 1);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(N_WIN - 1);

    state_e state_q, state_d;

    logic [PC_W-1:0] pc_q;
    logic [PR_W-1:0] pr_q;
    logic [SP_W-1:0] cs_q;
    logic [SP_W-1:0] rs_q;
    logic [WC_W-1:0] win_cnt_q;

    logic                  out_valid_q;
    logic                  out_last_q;
    logic [K*K*DATA_W-1:0] out_window_q;

    logic                       w_interior;
    logic                       w_adv;
    logic                       w_row_end;
    logic                       w_frame_end;
    logic                       w_done;
    logic                       w_last_win;
    logic [DATA_W-1:0]          w_pix;
    logic [K-2:0][DATA_W-1:0]   w_lb;
    logic [K-1:0][DATA_W-1:0]   w_col;
    logic [K*K*DATA_W-1:0]      w_win_next;
    logic [HW-1:0]              hist_q;
    logic [HW-1:0]              hist_d;

    always_comb begin
        w_interior  = (int'(pr_q) >= PAD) && (int'(pr_q) < PAD + IMG_H) &&
                      (int'(pc_q) >= PAD) && (int'(pc_q) < PAD + IMG_W);
        w_row_end   = (pc_q == PC_LAST);
        w_frame_end = w_row_end && (pr_q == PR_LAST);
        w_pix       = w_interior ? bus.in_data : '0;
        w_last_win  = (win_cnt_q == WIN_LAST);
        w_done      = w_adv && (int'(pr_q) >= K - 1) && (int'(pc_q) >= K - 1) &&
                      (cs_q == '0) && (rs_q == '0);
    end

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
            ST_RUN:  if (w_adv && w_frame_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clr) state_d = ST_IDLE;
    end

    always_comb begin
        busy         = (state_q == ST_RUN);
        bus.in_ready = (state_q == ST_RUN) && w_interior;
        w_adv        = (state_q == ST_RUN) && !clr && (!w_interior || bus.in_valid);
    end

    // Stride phases restart at every row/frame so the first window is always on the grid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            pr_q <= '0;
            cs_q <= '0;
            rs_q <= '0;
        end else if (clr) begin
            pc_q <= '0;
            pr_q <= '0;
            cs_q <= '0;
            rs_q <= '0;
        end else if (w_adv) begin
            if (w_row_end) begin
                pc_q <= '0;
                cs_q <= '0;
                if (pr_q == PR_LAST) begin
                    pr_q <= '0;
                    rs_q <= '0;
                end else begin
                    pr_q <= pr_q + 1'b1;
                    if (int'(pr_q) >= K - 1) rs_q <= (rs_q == SP_LAST) ? '0 : rs_q + 1'b1;
                end
            end else begin
                pc_q <= pc_q + 1'b1;
                if (int'(pc_q) >= K - 1) cs_q <= (cs_q == SP_LAST) ? '0 : cs_q + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        logic [DATA_W-1:0] w_d;
        if (j == 0) begin : g_head
            assign w_d = w_pix;
        end else begin : g_chain
            assign w_d = w_lb[j-1];
        end
        row_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (TW)
        ) u_row_delay (
            .clk  (clk),
            .en_i (w_adv),
            .d_i  (w_d),
            .q_o  (w_lb[j])
        );
    end

    // Deepest line buffer is the oldest (top) row; the live pixel is the bottom row.
    for (genvar r = 0; r < K; r++) begin : g_col
        if (r == K - 1) begin : g_live
            assign w_col[r] = w_pix;
        end else begin : g_buf
            assign w_col[r] = w_lb[K-2-r];
        end
    end

    // hist_q keeps the right-most K-1 columns of the current window.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_cell
            if (c < K - 1) begin : g_old
                assign w_win_next[(r*K+c)*DATA_W +: DATA_W] = hist_q[(r*(K-1)+c)*DATA_W +: DATA_W];
            end else begin : g_new
                assign w_win_next[(r*K+c)*DATA_W +: DATA_W] = w_col[r];
            end
            if (c > 0) begin : g_hist
                assign hist_d[(r*(K-1)+c-1)*DATA_W +: DATA_W] = w_win_next[(r*K+c)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) hist_q <= hist_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
            win_cnt_q    <= '0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            win_cnt_q   <= '0;
        end else begin
            out_valid_q <= w_done;
            out_last_q  <= w_done && w_last_win;
            if (w_done) begin
                out_window_q <= w_win_next;
                win_cnt_q    <= w_last_win ? '0 : win_cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_window = out_window_q;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_window_gen : scoreboard bench for window_gen (4x4 s1, 4x4 s2, 28x28)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_window_gen;
    import cnn_pkg::*;

    localparam int DW = 8;
    localparam int KK = 3;

    typedef struct packed {
        logic [KK*KK*DW-1:0] win;
        logic                last;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clr_a  = 1'b0;
    logic clr_off = 1'b0;
    logic busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    window_gen_if #(.DATA_W(DW), .K(KK)) if_a ();
    window_gen_if #(.DATA_W(DW), .K(KK)) if_b ();
    window_gen_if #(.DATA_W(DW), .K(KK)) if_c ();

    window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .K(KK), .PAD(1), .STRIDE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(if_a), .busy(busy_a));
    window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .K(KK), .PAD(1), .STRIDE(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_off), .bus(if_b), .busy(busy_b));
    window_gen #(.DATA_W(DW)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr_off), .bus(if_c), .busy(busy_c));

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   lasts_c = 0;
    bit   abort_a = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference: enumerate window origins on the padded grid and read pixels directly.
    function automatic void build_expected(input int which, input int iw, input int ih,
                                           input int pad, input int s, input int img[$]);
        int tw = iw + 2 * pad;
        int th = ih + 2 * pad;
        for (int wr = 0; wr + KK <= th; wr += s) begin
            for (int wc = 0; wc + KK <= tw; wc += s) begin
                exp_t e;
                e.win = '0;
                for (int r = 0; r < KK; r++) begin
                    for (int c = 0; c < KK; c++) begin
                        int pr = wr + r;
                        int pc = wc + c;
                        int v  = 0;
                        if (pr >= pad && pr < pad + ih && pc >= pad && pc < pad + iw)
                            v = img[(pr - pad) * iw + (pc - pad)];
                        e.win[(r*KK+c)*DW +: DW] = v[DW-1:0];
                    end
                end
                e.last = (wr + s + KK > th) && (wc + s + KK > tw);
                case (which)
                    0:       q_a.push_back(e);
                    1:       q_b.push_back(e);
                    default: q_c.push_back(e);
                endcase
            end
        end
    endfunction

    always @(negedge clk) begin
        if (if_a.out_valid) begin
            if (abort_a) begin
                check("a_abort_last", {127'd0, if_a.out_last}, 128'd0);
            end else if (q_a.size() == 0) begin
                n_chk++;
                $display("FAIL a_extra: got window %0h expected none", if_a.out_window);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_window", {56'd0, if_a.out_window}, {56'd0, e.win});
                check("a_last", {127'd0, if_a.out_last}, {127'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (if_b.out_valid) begin
            if (q_b.size() == 0) begin
                n_chk++;
                $display("FAIL b_extra: got window %0h expected none", if_b.out_window);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_window", {56'd0, if_b.out_window}, {56'd0, e.win});
                check("b_last", {127'd0, if_b.out_last}, {127'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (if_c.out_valid) begin
            if (if_c.out_last) lasts_c++;
            if (q_c.size() == 0) begin
                n_chk++;
                $display("FAIL c_extra: got window %0h expected none", if_c.out_window);
            end else begin
                exp_t e;
                e = q_c.pop_front();
                check("c_window", {56'd0, if_c.out_window}, {56'd0, e.win});
                check("c_last", {127'd0, if_c.out_last}, {127'd0, e.last});
            end
        end
    end

    task automatic set_in(input int sel, input logic v, input logic [DW-1:0] d);
        case (sel)
            0:       begin if_a.in_valid = v; if_a.in_data = d; end
            1:       begin if_b.in_valid = v; if_b.in_data = d; end
            default: begin if_c.in_valid = v; if_c.in_data = d; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if_a.in_ready;
            1:       return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // vmode 0: valid always high, 1: toggling, 2: random. stop_after<0 runs the full frame.
    task automatic drive_frame(input int sel, input int img[$], input int vmode, input int stop_after,
                               output int run_cyc, output int pad_cyc, output int xfer);
        int   idx     = 0;
        int   cyc     = 0;
        bit   started = 1'b0;
        bit   done    = 1'b0;
        logic v;
        run_cyc = 0;
        pad_cyc = 0;
        xfer    = 0;
        while (cyc < 5000 && !done) begin
            @(negedge clk);
            if (get_busy(sel)) begin
                run_cyc++;
                started = 1'b1;
                if (!get_ready(sel)) pad_cyc++;
            end else if (started) begin
                done = 1'b1;
            end
            if (!done && stop_after >= 0 && idx >= stop_after) begin
                done = 1'b1;
            end
            if (done) begin
                set_in(sel, 1'b0, '0);
            end else begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                if (idx >= img.size()) v = 1'b0;
                set_in(sel, v, v ? DW'(img[idx]) : '0);
                if (v && get_ready(sel)) begin
                    idx++;
                    xfer++;
                end
                cyc++;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL frame_timeout: got %0d cycles expected frame end", cyc);
            set_in(sel, 1'b0, '0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int img4[$];
        int imgc[$];
        int run_cyc, pad_cyc, xfer;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img4.push_back(r * 4 + c + 1);
        for (int i = 0; i < 28 * 28; i++) imgc.push_back(int'($urandom_range(0, 255)));

        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        set_in(2, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("rst_in_ready", {127'd0, if_a.in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, if_a.out_valid}, 128'd0);
        check("rst_out_last", {127'd0, if_a.out_last}, 128'd0);
        check("rst_busy", {127'd0, busy_a}, 128'd0);
        check("rst_window", {56'd0, if_a.out_window}, 128'd0);
        rst_n = 1'b1;

        // Baseline frame, valid always high.
        build_expected(0, 4, 4, 1, 1, img4);
        drive_frame(0, img4, 0, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("base_run_cycles", 128'(run_cyc), 128'd36);
        check("base_xfers", 128'(xfer), 128'd16);
        check("base_drained", 128'(q_a.size()), 128'd0);

        // Toggling valid: same windows, in_ready low at exactly the pad positions.
        build_expected(0, 4, 4, 1, 1, img4);
        drive_frame(0, img4, 1, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("toggle_pad_cycles", 128'(pad_cyc), 128'd20);
        check("toggle_xfers", 128'(xfer), 128'd16);
        check("toggle_drained", 128'(q_a.size()), 128'd0);

        // Abort with clr after 10 pixels, then a clean frame.
        abort_a = 1'b1;
        drive_frame(0, img4, 0, 10, run_cyc, pad_cyc, xfer);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clr_out_valid", {127'd0, if_a.out_valid}, 128'd0);
        check("clr_out_last", {127'd0, if_a.out_last}, 128'd0);
        check("clr_busy", {127'd0, busy_a}, 128'd0);
        abort_a = 1'b0;
        build_expected(0, 4, 4, 1, 1, img4);
        drive_frame(0, img4, 0, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("post_clr_run_cycles", 128'(run_cyc), 128'd36);
        check("post_clr_drained", 128'(q_a.size()), 128'd0);

        // Asynchronous reset mid-frame, then a clean frame.
        abort_a = 1'b1;
        drive_frame(0, img4, 0, 7, run_cyc, pad_cyc, xfer);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {127'd0, if_a.in_ready}, 128'd0);
        check("arst_out_valid", {127'd0, if_a.out_valid}, 128'd0);
        check("arst_out_last", {127'd0, if_a.out_last}, 128'd0);
        check("arst_busy", {127'd0, busy_a}, 128'd0);
        check("arst_window", {56'd0, if_a.out_window}, 128'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        abort_a = 1'b0;
        build_expected(0, 4, 4, 1, 1, img4);
        drive_frame(0, img4, 0, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("post_rst_run_cycles", 128'(run_cyc), 128'd36);
        check("post_rst_drained", 128'(q_a.size()), 128'd0);

        // Stride 2 on the same frame.
        build_expected(1, 4, 4, 1, 2, img4);
        check("s2_expected_count", 128'(q_b.size()), 128'd4);
        drive_frame(1, img4, 0, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("s2_run_cycles", 128'(run_cyc), 128'd36);
        check("s2_drained", 128'(q_b.size()), 128'd0);

        // Default geometry with random pixels and random valid.
        build_expected(2, 28, 28, 1, 1, imgc);
        check("c_expected_count", 128'(q_c.size()), 128'd784);
        drive_frame(2, imgc, 2, -1, run_cyc, pad_cyc, xfer);
        repeat (2) @(negedge clk);
        check("c_xfers", 128'(xfer), 128'd784);
        check("c_drained", 128'(q_c.size()), 128'd0);
        check("c_last_count", 128'(lasts_c), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
